// File: rtl/grf_pkg.sv
// Shared constants and state encoding for the multi-port register file.
// Also used by the decode stage and the hazard unit.
package grf_pkg;

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    localparam int unsigned GRF_DATA_W = 32;
    localparam int unsigned GRF_ADDR_W = 5;

    typedef enum logic {
        StClear = ST_CLEAR,
        StRun   = ST_RUN
    } grf_state_e;

endpackage

// File: rtl/grf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared by the write.
// Lookup ports mask registers whose write is being forwarded this cycle.
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int unsigned ADDR_W   = GRF_ADDR_W,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  sb_set_i,
    input  logic [ADDR_W-1:0]     sb_addr_i,
    input  logic [NWR-1:0]        we_i,
    input  logic [NWR*ADDR_W-1:0] wa_i,
    input  logic [NRD*ADDR_W-1:0] ra_i,
    output logic [NRD-1:0]        rbusy_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [ADDR_W-1:0] wa_a [NWR];
    logic [ADDR_W-1:0] ra_a [NRD];
    logic [NWR-1:0]    wr_ok;
    logic              set_ok;
    logic [DEPTH-1:0]  sb_q, sb_d, set_vec, clr_vec;

    for (genvar k = 0; k < NWR; k++) begin : g_wr
        assign wa_a[k]  = wa_i[k*ADDR_W +: ADDR_W];
        assign wr_ok[k] = en_i & we_i[k] & ((ZERO_REG == 0) || (wa_a[k] != '0));
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        assign ra_a[r] = ra_i[r*ADDR_W +: ADDR_W];
    end

    assign set_ok = en_i & sb_set_i & ((ZERO_REG == 0) || (sb_addr_i != '0));

    // Set after clear so a new producer issued on the write edge stays pending.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int k = 0; k < NWR; k++) begin
            if (wr_ok[k]) clr_vec[wa_a[k]] = 1'b1;
        end
        if (set_ok) set_vec[sb_addr_i] = 1'b1;
        sb_d = set_vec | (sb_q & ~clr_vec);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sb_q <= '0;
        else         sb_q <= sb_d;
    end

    always_comb begin
        rbusy_o = '0;
        for (int r = 0; r < NRD; r++) begin
            rbusy_o[r] = en_i & sb_q[ra_a[r]];
            for (int k = 0; k < NWR; k++) begin
                if (wr_ok[k] && (wa_a[k] == ra_a[r])) rbusy_o[r] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/grf_mp.sv
// Multi-port register file with same-cycle write forwarding, pending-write scoreboard
// and a post-reset clear sweep that zeroes the array one entry per clock.
module grf_mp
    import grf_pkg::*;
#(
    parameter int unsigned DATA_W   = GRF_DATA_W,
    parameter int unsigned ADDR_W   = GRF_ADDR_W,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*DATA_W-1:0] rd,
    output logic [NRD-1:0]        rbusy,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*ADDR_W-1:0] wa,
    input  logic [NWR*DATA_W-1:0] wd,
    input  logic                  sb_set,
    input  logic [ADDR_W-1:0]     sb_addr,
    output logic                  ready
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    grf_state_e        state_q;
    logic [ADDR_W:0]   clr_ptr_q;
    logic              ready_q;
    logic              run;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wa_a  [NWR];
    logic [DATA_W-1:0] wd_a  [NWR];
    logic [ADDR_W-1:0] ra_a  [NRD];
    logic [DATA_W-1:0] rd_a  [NRD];
    logic [NWR-1:0]    wr_ok;

    assign run   = (state_q == StRun);
    assign ready = ready_q;

    for (genvar k = 0; k < NWR; k++) begin : g_wr
        assign wa_a[k]  = wa[k*ADDR_W +: ADDR_W];
        assign wd_a[k]  = wd[k*DATA_W +: DATA_W];
        assign wr_ok[k] = run & we[k] & ((ZERO_REG == 0) || (wa_a[k] != '0));
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        assign ra_a[r]              = ra[r*ADDR_W +: ADDR_W];
        assign rd[r*DATA_W +: DATA_W] = rd_a[r];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
        end else if (state_q == StClear) begin
            clr_ptr_q <= clr_ptr_q + (ADDR_W+1)'(1);
            if (clr_ptr_q == (ADDR_W+1)'(DEPTH - 1)) begin
                state_q <= StRun;
                ready_q <= 1'b1;
            end
        end
    end

    // Storage has no reset; the sweep owns initialisation. Later ports override earlier ones.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem_q[clr_ptr_q[ADDR_W-1:0]] <= '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_ok[k]) mem_q[wa_a[k]] <= wd_a[k];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            rd_a[r] = mem_q[ra_a[r]];
            for (int k = 0; k < NWR; k++) begin
                if (wr_ok[k] && (wa_a[k] == ra_a[r])) rd_a[r] = wd_a[k];
            end
            if (!run || ((ZERO_REG != 0) && (ra_a[r] == '0))) rd_a[r] = '0;
        end
    end

    grf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i     (clk),
        .rst_ni    (reset),
        .en_i      (run),
        .sb_set_i  (sb_set),
        .sb_addr_i (sb_addr),
        .we_i      (we),
        .wa_i      (wa),
        .ra_i      (ra),
        .rbusy_o   (rbusy)
    );

endmodule

// File: tb/tb_grf_mp.sv
// Directed self-checking bench for grf_mp with default parameters.
module tb_grf_mp;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NRD    = 2;
    localparam int unsigned NWR    = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NRD*ADDR_W-1:0] ra;
    logic [NRD*DATA_W-1:0] rd;
    logic [NRD-1:0]        rbusy;
    logic [NWR-1:0]        we;
    logic [NWR*ADDR_W-1:0] wa;
    logic [NWR*DATA_W-1:0] wd;
    logic                  sb_set;
    logic [ADDR_W-1:0]     sb_addr;
    logic                  ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    grf_mp #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ra      (ra),
        .rd      (rd),
        .rbusy   (rbusy),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .sb_set  (sb_set),
        .sb_addr (sb_addr),
        .ready   (ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we      = '0;
        wa      = '0;
        wd      = '0;
        sb_set  = 1'b0;
        sb_addr = '0;
    endtask

    // Counts edges until ready rises (bounded) and tallies nonzero rd/rbusy seen on the way.
    task automatic sweep(output int edges, output int bad);
        edges = 0;
        bad   = 0;
        for (int i = 0; i < 40; i++) begin
            if (rd != '0 || rbusy != '0) bad++;
            tick();
            edges++;
            if (ready) break;
        end
    endtask

    int edges, bad;

    initial begin
        reset = 1'b0;
        ra    = '0;
        idle();
        #2;
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_rbusy", {62'd0, rbusy}, 64'd0);
        repeat (3) tick();
        reset = 1'b1;

        // Writes and sb_set during the sweep must be ignored.
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'd0, 32'hAAAA_AAAA};
        sb_set = 1'b1; sb_addr = 5'd3;
        ra = {5'd3, 5'd7};
        sweep(edges, bad);
        check("sweep1_edges", 64'(edges), 64'd32);
        check("sweep1_rd_zero", 64'(bad), 64'd0);
        idle();
        #1;
        check("clr_ignored_wr", {32'd0, rd[63:32]}, 64'd0);
        check("clr_ignored_sb", {62'd0, rbusy}, 64'd0);

        // Write and bypass.
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'd0, 32'h1234_5678}; ra = {5'd0, 5'd3};
        #1;
        check("bypass_rd0", {32'd0, rd[31:0]}, 64'h1234_5678);
        tick();
        idle();
        #1;
        check("stored_rd0", {32'd0, rd[31:0]}, 64'h1234_5678);

        // Collision on address 9: port 1 wins.
        we = 2'b11; wa = {5'd9, 5'd9}; wd = {32'h2, 32'h1}; ra = {5'd9, 5'd3};
        #1;
        check("coll_bypass", {32'd0, rd[63:32]}, 64'h2);
        tick();
        idle();
        #1;
        check("coll_stored", {32'd0, rd[63:32]}, 64'h2);

        // Zero register.
        we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'd0, 32'hFFFF_FFFF};
        sb_set = 1'b1; sb_addr = 5'd0; ra = {5'd0, 5'd0};
        #1;
        check("zero_bypass", {32'd0, rd[31:0]}, 64'd0);
        check("zero_busy_pre", {62'd0, rbusy}, 64'd0);
        tick();
        idle();
        #1;
        check("zero_stored", {32'd0, rd[31:0]}, 64'd0);
        check("zero_busy_post", {62'd0, rbusy}, 64'd0);

        // Scoreboard set, then write+set collision, then lone write.
        sb_set = 1'b1; sb_addr = 5'd5; ra = {5'd5, 5'd5};
        #1;
        check("sb_busy_pre", {62'd0, rbusy}, 64'd0);
        tick();
        idle();
        #1;
        check("sb_busy_set", {62'd0, rbusy}, 64'd3);
        we = 2'b10; wa = {5'd5, 5'd0}; wd = {32'hCAFE_F00D, 32'd0};
        sb_set = 1'b1; sb_addr = 5'd5;
        #1;
        check("sb_coll_rd", {32'd0, rd[31:0]}, 64'hCAFE_F00D);
        check("sb_coll_busy", {62'd0, rbusy}, 64'd0);
        tick();
        idle();
        #1;
        check("sb_coll_after", {62'd0, rbusy}, 64'd3);
        sb_set = 1'b1; sb_addr = 5'd5;
        tick();
        idle();
        we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'h55};
        #1;
        check("sb_lone_busy", {62'd0, rbusy}, 64'd0);
        tick();
        idle();
        #1;
        check("sb_lone_after", {62'd0, rbusy}, 64'd0);
        check("sb_lone_rd", {32'd0, rd[63:32]}, 64'h55);

        // Preload 7, mark 4 and 6 pending, then reset mid-RUN.
        we = 2'b10; wa = {5'd7, 5'd0}; wd = {32'hDEAD_BEEF, 32'd0};
        sb_set = 1'b1; sb_addr = 5'd4;
        tick();
        idle();
        sb_set = 1'b1; sb_addr = 5'd6;
        tick();
        idle();
        ra = {5'd6, 5'd4};
        #1;
        check("pre_rst_busy", {62'd0, rbusy}, 64'd3);
        ra = {5'd7, 5'd7};
        #1;
        check("pre_rst_rd7", {32'd0, rd[31:0]}, 64'hDEAD_BEEF);
        reset = 1'b0;
        #1;
        check("rst_run_ready", {63'd0, ready}, 64'd0);
        check("rst_run_rd", rd, 64'd0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (10) tick();
        check("mid_clr_ready", {63'd0, ready}, 64'd0);
        reset = 1'b0;
        #1;
        check("rst_clr_ready", {63'd0, ready}, 64'd0);
        tick();
        reset = 1'b1;
        sweep(edges, bad);
        check("sweep2_edges", 64'(edges), 64'd32);
        check("sweep2_rd_zero", 64'(bad), 64'd0);
        #1;
        check("sweep2_rd7", {32'd0, rd[31:0]}, 64'd0);
        ra = {5'd6, 5'd4};
        #1;
        check("sweep2_busy", {62'd0, rbusy}, 64'd0);
        check("sweep2_ready", {63'd0, ready}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
